alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command front-end for an 8-bit ALU. A command accepted over cmd_valid/cmd_ready is
//   registered onto the ALU inputs and held for SETTLE_CYCLES cycles. The ALU result and
//   flags are then captured and offered over res_valid/res_ready. Each captured result
//   is also kept in an accumulator, and cmd_chain selects it as operand A.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_op, cmd_a, cmd_b       opcode and operands
//   cmd_chain                  use the accumulator instead of cmd_a
//   alu_sel, alu_a, alu_b      registered ALU inputs
//   alu_out, alu_co, alu_z     ALU result and flags (combinational from ALU)
//   res_valid/ready            result handshake
//   res_data, res_co, res_z    captured result and flags
//   op_count                   completed-operation counter (wraps)
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic       cmd_chain,
    output logic [1:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_z,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_co,
    output logic       res_z,
    output logic [7:0] op_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : gBadSettle
        $error("alu_op_sequencer: SETTLE_CYCLES=%0d outside legal range 1..15", SETTLE_CYCLES);
    end

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

    logic [1:0] stateQ, stateD;
    logic [3:0] cntQ, cntD;
    logic [1:0] aluSelQ, aluSelD;
    logic [7:0] aluAQ, aluAD;
    logic [7:0] aluBQ, aluBD;
    logic [7:0] resDataQ, resDataD;
    logic       resCoQ, resCoD;
    logic       resZQ, resZD;
    logic [7:0] accQ, accD;
    logic [7:0] opCountQ, opCountD;

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        aluSelD  = aluSelQ;
        aluAD    = aluAQ;
        aluBD    = aluBQ;
        resDataD = resDataQ;
        resCoD   = resCoQ;
        resZD    = resZQ;
        accD     = accQ;
        opCountD = opCountQ;
        case (stateQ)
            IDLE: begin
                if (cmd_valid) begin
                    aluSelD = cmd_op;
                    aluAD   = cmd_chain ? accQ : cmd_a;
                    aluBD   = cmd_b;
                    cntD    = 4'd0;
                    stateD  = DRIVE;
                end
            end
            DRIVE: begin
                // Counter starts at 0 on the first DRIVE cycle, so capture lands
                // exactly SETTLE_CYCLES edges after the accept edge.
                if (cntQ == LastCnt) begin
                    resDataD = alu_out;
                    resCoD   = alu_co;
                    resZD    = alu_z;
                    accD     = alu_out;
                    opCountD = opCountQ + 8'd1;
                    stateD   = RESULT;
                end else begin
                    cntD = cntQ + 4'd1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ   <= IDLE;
            cntQ     <= 4'd0;
            aluSelQ  <= 2'd0;
            aluAQ    <= 8'd0;
            aluBQ    <= 8'd0;
            resDataQ <= 8'd0;
            resCoQ   <= 1'b0;
            resZQ    <= 1'b0;
            accQ     <= 8'd0;
            opCountQ <= 8'd0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            aluSelQ  <= aluSelD;
            aluAQ    <= aluAD;
            aluBQ    <= aluBD;
            resDataQ <= resDataD;
            resCoQ   <= resCoD;
            resZQ    <= resZD;
            accQ     <= accD;
            opCountQ <= opCountD;
        end
    end

    assign cmd_ready = (stateQ == IDLE);
    assign res_valid = (stateQ == RESULT);
    assign alu_sel   = aluSelQ;
    assign alu_a     = aluAQ;
    assign alu_b     = aluBQ;
    assign res_data  = resDataQ;
    assign res_co    = resCoQ;
    assign res_z     = resZQ;
    assign op_count  = opCountQ;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two instances: index 0 has SETTLE_CYCLES=1, index 1 has SETTLE_CYCLES=3.
    logic       rstN     [2];
    logic       cmdValid [2];
    logic       cmdReady [2];
    logic [1:0] cmdOp    [2];
    logic [7:0] cmdA     [2];
    logic [7:0] cmdB     [2];
    logic       cmdChain [2];
    logic [1:0] aluSel   [2];
    logic [7:0] aluA     [2];
    logic [7:0] aluB     [2];
    logic [7:0] aluOut   [2];
    logic       aluCo    [2];
    logic       aluZ     [2];
    logic       resValid [2];
    logic       resReady [2];
    logic [7:0] resData  [2];
    logic       resCo    [2];
    logic       resZ     [2];
    logic [7:0] opCount  [2];

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: accumulator and completed-op count per instance.
    logic [7:0] accM [2];
    int         cntM [2];
    int         settle [2];

    // ALU behaviour from the test plan: returns {co, z, out}.
    function automatic logic [9:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a & b};
            2'b10:   r = {1'b0, a | b};
            default: r = {1'b0, ~a};
        endcase
        return {r[8], (r[7:0] == 8'h00), r[7:0]};
    endfunction

    for (genvar i = 0; i < 2; i++) begin : gDut
        assign {aluCo[i], aluZ[i], aluOut[i]} = alu_ref(aluSel[i], aluA[i], aluB[i]);

        alu_op_sequencer #(.SETTLE_CYCLES(i == 0 ? 1 : 3)) dut (
            .clk       (clk),
            .rst_n     (rstN[i]),
            .cmd_valid (cmdValid[i]),
            .cmd_ready (cmdReady[i]),
            .cmd_op    (cmdOp[i]),
            .cmd_a     (cmdA[i]),
            .cmd_b     (cmdB[i]),
            .cmd_chain (cmdChain[i]),
            .alu_sel   (aluSel[i]),
            .alu_a     (aluA[i]),
            .alu_b     (aluB[i]),
            .alu_out   (aluOut[i]),
            .alu_co    (aluCo[i]),
            .alu_z     (aluZ[i]),
            .res_valid (resValid[i]),
            .res_ready (resReady[i]),
            .res_data  (resData[i]),
            .res_co    (resCo[i]),
            .res_z     (resZ[i]),
            .op_count  (opCount[i])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, wait for the result, optionally stall res_ready for `stall`
    // cycles (pulsing a competing command), then release and check the return to IDLE.
    task automatic run_op(input int d, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic chain, input int stall,
                          input string tag);
        logic [7:0] expA;
        logic [9:0] expR;
        int         cycles;
        expA = chain ? accM[d] : a;
        expR = alu_ref(op, expA, b);
        cmdOp[d]    = op;
        cmdA[d]     = a;
        cmdB[d]     = b;
        cmdChain[d] = chain;
        cmdValid[d] = 1'b1;
        resReady[d] = (stall == 0);
        compared++;
        if (cmdReady[d] !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_ready dut%0d: got %b expected 1", tag, d, cmdReady[d]);
        end
        step();
        cmdValid[d] = 1'b0;
        compared++;
        if ({aluSel[d], aluA[d], aluB[d]} !== {op, expA, b}) begin
            mismatched++;
            $display("FAIL %s_issue dut%0d: got sel=%0h a=%h b=%h expected sel=%0h a=%h b=%h",
                     tag, d, aluSel[d], aluA[d], aluB[d], op, expA, b);
        end
        cycles = 0;
        while (resValid[d] !== 1'b1 && cycles < 40) begin
            compared++;
            if ({aluSel[d], aluA[d], aluB[d], cmdReady[d]} !== {op, expA, b, 1'b0}) begin
                mismatched++;
                $display("FAIL %s_drive_hold dut%0d: got a=%h b=%h rdy=%b expected a=%h b=%h rdy=0",
                         tag, d, aluA[d], aluB[d], cmdReady[d], expA, b);
            end
            step();
            cycles++;
        end
        compared++;
        if (cycles != settle[d]) begin
            mismatched++;
            $display("FAIL %s_latency dut%0d: got %0d expected %0d", tag, d, cycles, settle[d]);
        end
        compared++;
        if ({resCo[d], resZ[d], resData[d]} !== expR) begin
            mismatched++;
            $display("FAIL %s_result dut%0d: got co=%b z=%b data=%h expected co=%b z=%b data=%h",
                     tag, d, resCo[d], resZ[d], resData[d], expR[9], expR[8], expR[7:0]);
        end
        cntM[d] = (cntM[d] + 1) % 256;
        accM[d] = expR[7:0];
        compared++;
        if (opCount[d] !== 8'(cntM[d])) begin
            mismatched++;
            $display("FAIL %s_count dut%0d: got %0d expected %0d", tag, d, opCount[d], cntM[d]);
        end
        for (int k = 0; k < stall; k++) begin
            if (k == 1) begin
                cmdValid[d] = 1'b1;
                cmdA[d]     = ~expA;
                cmdChain[d] = 1'b0;
            end
            step();
            cmdValid[d] = 1'b0;
            compared++;
            if ({resValid[d], cmdReady[d], resData[d], aluA[d], opCount[d]} !==
                {1'b1, 1'b0, expR[7:0], expA, 8'(cntM[d])}) begin
                mismatched++;
                $display("FAIL %s_stall dut%0d: got v=%b rdy=%b data=%h a=%h cnt=%0d expected v=1 rdy=0 data=%h a=%h cnt=%0d",
                         tag, d, resValid[d], cmdReady[d], resData[d], aluA[d], opCount[d],
                         expR[7:0], expA, cntM[d]);
            end
        end
        resReady[d] = 1'b1;
        step();
        compared++;
        if ({resValid[d], cmdReady[d], aluA[d], opCount[d]} !==
            {1'b0, 1'b1, expA, 8'(cntM[d])}) begin
            mismatched++;
            $display("FAIL %s_release dut%0d: got v=%b rdy=%b a=%h cnt=%0d expected v=0 rdy=1 a=%h cnt=%0d",
                     tag, d, resValid[d], cmdReady[d], aluA[d], opCount[d], expA, cntM[d]);
        end
    endtask

    task automatic reset_dut(input int d, input string tag);
        rstN[d] = 1'b0;
        step();
        compared++;
        if ({cmdReady[d], resValid[d], aluSel[d], aluA[d], aluB[d], resData[d], resCo[d],
             resZ[d], opCount[d]} !== {1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0}) begin
            mismatched++;
            $display("FAIL %s dut%0d: got rdy=%b v=%b sel=%0h a=%h b=%h data=%h co=%b z=%b cnt=%0d expected rdy=1 v=0 all else 0",
                     tag, d, cmdReady[d], resValid[d], aluSel[d], aluA[d], aluB[d],
                     resData[d], resCo[d], resZ[d], opCount[d]);
        end
        rstN[d] = 1'b1;
        accM[d] = 8'd0;
        cntM[d] = 0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            reset_dut(d, "reset");
        end
    endtask

    task automatic test_add_basic();
        run_op(0, 2'b00, 8'hA5, 8'h87, 1'b0, 0, "add_basic");
    endtask

    task automatic test_stall();
        run_op(1, 2'b01, 8'hB5, 8'hA9, 1'b0, 5, "stall");
    endtask

    task automatic test_chain();
        run_op(0, 2'b00, 8'h01, 8'hFF, 1'b0, 0, "chain_first");
        run_op(0, 2'b10, 8'hEE, 8'h69, 1'b1, 0, "chain_second");
    endtask

    task automatic test_reset_abort();
        int seen;
        cmdOp[1]    = 2'b00;
        cmdA[1]     = 8'h12;
        cmdB[1]     = 8'h34;
        cmdChain[1] = 1'b0;
        cmdValid[1] = 1'b1;
        resReady[1] = 1'b1;
        step();
        cmdValid[1] = 1'b0;
        step();
        rstN[1] = 1'b0;
        step();
        rstN[1] = 1'b1;
        accM[1] = 8'd0;
        cntM[1] = 0;
        compared++;
        if ({resValid[1], cmdReady[1], opCount[1]} !== {1'b0, 1'b1, 8'd0}) begin
            mismatched++;
            $display("FAIL abort_state dut1: got v=%b rdy=%b cnt=%0d expected v=0 rdy=1 cnt=0",
                     resValid[1], cmdReady[1], opCount[1]);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (resValid[1] === 1'b1) seen++;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL abort_no_result dut1: got %0d valid cycles expected 0", seen);
        end
        // Chaining right after the abort must see a cleared accumulator.
        run_op(1, 2'b10, 8'hFF, 8'h3C, 1'b1, 0, "abort_chain");
    endtask

    task automatic test_back_to_back();
        reset_dut(0, "b2b_reset");
        for (int n = 0; n < 256; n++) begin
            run_op(0, 2'b11, 8'h69, 8'($urandom), 1'b0, 0, "b2b");
        end
        compared++;
        if (opCount[0] !== 8'd0) begin
            mismatched++;
            $display("FAIL b2b_wrap dut0: got %0d expected 0", opCount[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op(n % 2, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        settle[0] = 1;
        settle[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rstN[d]     = 1'b0;
            cmdValid[d] = 1'b0;
            cmdOp[d]    = 2'd0;
            cmdA[d]     = 8'd0;
            cmdB[d]     = 8'd0;
            cmdChain[d] = 1'b0;
            resReady[d] = 1'b0;
            accM[d]     = 8'd0;
            cntM[d]     = 0;
        end
        step();
        test_reset();
        test_add_basic();
        test_stall();
        test_chain();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
